fifo_ctrl8: RTL and testbench

Control stage for the 8-entry, 32-bit FIFO. It tracks head/tail pointers and occupancy, and runs the FIFO state machine. It drives the one-hot write enables and read select that feed the downstream register bank of eight resettable 32-bit flip-flops and the read-output register. The block holds no data itself: it decides which bank entry is written or read on every clock edge and reports status and handshake results.

---
 rtl/fifo_ctrl8.sv | 125 ++++++++++++
 tb/tb_fifo_ctrl8.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl8.sv
// Control stage for the 8-entry, 32-bit FIFO: pointers, occupancy, FSM, bank enables
// and registered handshake flags. Holds no data; the bank and read register live outside.
module fifo_ctrl8 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic [7:0] we,
  output logic       wr_fire,
  output logic       rd_fire,
  output logic [2:0] rd_sel,
  output logic [2:0] state,
  output logic [3:0] data_count,
  output logic       full,
  output logic       empty,
  output logic       wr_ack,
  output logic       wr_err,
  output logic       rd_ack,
  output logic       rd_err
);

  localparam logic [2:0] INIT     = 3'd0;
  localparam logic [2:0] NO_OP    = 3'd1;
  localparam logic [2:0] WRITE    = 3'd2;
  localparam logic [2:0] WR_ERROR = 3'd3;
  localparam logic [2:0] READ     = 3'd4;
  localparam logic [2:0] RD_ERROR = 3'd5;

  localparam logic [3:0] Depth = 4'd8;

  logic [2:0] head_q, head_d;
  logic [2:0] tail_q, tail_d;
  logic [3:0] count_q, count_d;
  logic [2:0] state_q, state_d;
  logic       wr_ack_q, wr_ack_d;
  logic       wr_err_q, wr_err_d;
  logic       rd_ack_q, rd_ack_d;
  logic       rd_err_q, rd_err_d;

  logic wr_only;
  logic rd_only;
  logic wr_rej;
  logic rd_rej;

  // Simultaneous wr_en and rd_en is a deliberate no-op, so only exclusive requests decode.
  assign wr_only = wr_en & ~rd_en;
  assign rd_only = rd_en & ~wr_en;

  assign full  = (count_q == Depth);
  assign empty = (count_q == 4'd0);

  // Fire strobes are gated by reset so the bank never sees an enable while reset is held.
  assign wr_fire = reset_n & wr_only & ~full;
  assign rd_fire = reset_n & rd_only & ~empty;
  assign wr_rej  = wr_only & full;
  assign rd_rej  = rd_only & empty;

  always_comb begin
    we = 8'h00;
    if (wr_fire) begin
      we = 8'h01 << tail_q;
    end
  end

  assign rd_sel = head_q;

  // Next state is a function of the request and occupancy only; unused codes fall to NO_OP.
  always_comb begin
    state_d  = NO_OP;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    wr_ack_d = 1'b0;
    wr_err_d = 1'b0;
    rd_ack_d = 1'b0;
    rd_err_d = 1'b0;
    if (wr_fire) begin
      state_d  = WRITE;
      tail_d   = tail_q + 3'd1;
      count_d  = count_q + 4'd1;
      wr_ack_d = 1'b1;
    end else if (wr_rej) begin
      state_d  = WR_ERROR;
      wr_err_d = 1'b1;
    end else if (rd_fire) begin
      state_d  = READ;
      head_d   = head_q + 3'd1;
      count_d  = count_q - 4'd1;
      rd_ack_d = 1'b1;
    end else if (rd_rej) begin
      state_d  = RD_ERROR;
      rd_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= INIT;
      head_q   <= 3'd0;
      tail_q   <= 3'd0;
      count_q  <= 4'd0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign state      = state_q;
  assign data_count = count_q;
  assign wr_ack     = wr_ack_q;
  assign wr_err     = wr_err_q;
  assign rd_ack     = rd_ack_q;
  assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_fifo_ctrl8.sv
// Bench for fifo_ctrl8: external bank + read register, queue-based reference model,
// per-cycle comparison at the falling edge, directed scenarios then random traffic.
module tb_fifo_ctrl8;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] we;
  logic       wr_fire;
  logic       rd_fire;
  logic [2:0] rd_sel;
  logic [2:0] state;
  logic [3:0] data_count;
  logic       full;
  logic       empty;
  logic       wr_ack;
  logic       wr_err;
  logic       rd_ack;
  logic       rd_err;

  logic [31:0] wdata;

  fifo_ctrl8 dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .we         (we),
    .wr_fire    (wr_fire),
    .rd_fire    (rd_fire),
    .rd_sel     (rd_sel),
    .state      (state),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Downstream bank and read register, driven by the DUT's enables.
  logic [31:0] bank [8];
  logic [31:0] rdreg;
  logic [7:0]  we_s;
  logic        rd_fire_s;
  logic [2:0]  rd_sel_s;

  // Reference model: data queue plus pointer arithmetic, expected registered outputs.
  logic [31:0] q[$];
  int          mhead, mtail;
  int          mstate;
  bit          m_wa, m_we, m_ra, m_re;
  logic [31:0] exp_rdata;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      mhead = 0; mtail = 0; mstate = 0;
      m_wa = 0; m_we = 0; m_ra = 0; m_re = 0;
    end else begin
      for (int i = 0; i < 8; i++) if (we_s[i]) bank[i] = wdata;
      if (rd_fire_s) rdreg = bank[rd_sel_s];
      m_wa = 0; m_we = 0; m_ra = 0; m_re = 0;
      if (wr_en && !rd_en) begin
        if (q.size() < 8) begin
          q.push_back(wdata);
          mtail = (mtail + 1) % 8;
          mstate = 2; m_wa = 1;
        end else begin
          mstate = 3; m_we = 1;
        end
      end else if (rd_en && !wr_en) begin
        if (q.size() > 0) begin
          exp_rdata = q.pop_front();
          mhead = (mhead + 1) % 8;
          mstate = 4; m_ra = 1;
        end else begin
          mstate = 5; m_re = 1;
        end
      end else begin
        mstate = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_we;
    bit         ewf, erf;
    ewf = reset_n && wr_en && !rd_en && q.size() < 8;
    erf = reset_n && rd_en && !wr_en && q.size() > 0;
    exp_we = ewf ? (8'h01 << mtail) : 8'h00;
    chk("state", 32'(state), 32'(mstate));
    chk("count", 32'(data_count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == 8));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("we", 32'(we), 32'(exp_we));
    chk("wr_fire", 32'(wr_fire), 32'(ewf));
    chk("rd_fire", 32'(rd_fire), 32'(erf));
    chk("rd_sel", 32'(rd_sel), 32'(mhead));
    chk("flags", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'({m_wa, m_we, m_ra, m_re}));
    if (reset_n && m_ra) chk("rdata", rdreg, exp_rdata);
    we_s      = we;
    rd_fire_s = rd_fire;
    rd_sel_s  = rd_sel;
  end

  task automatic op(input logic w, input logic r, input logic [31:0] d);
    wr_en = w;
    rd_en = r;
    wdata = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  wrap_we [5];
  logic [31:0] wrap_val [5];
  logic [31:0] v;
  int          phase_wr;

  initial begin
    wr_en = 0; rd_en = 0; wdata = 0; reset_n = 0;
    we_s = 0; rd_fire_s = 0; rd_sel_s = 0; rdreg = 0;
    for (int i = 0; i < 8; i++) bank[i] = 0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    reset_n = 1;

    // Fill from empty.
    for (int i = 0; i < 8; i++) begin
      v = 32'h11111111 * (i + 1);
      op(1, 0, v);
      chk("fill_we", 32'(we), 32'(8'h01 << i));
      tick();
      chk("fill_ack", 32'(wr_ack), 32'd1);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(data_count), 32'd8);
    op(1, 0, 32'hDEADBEEF);
    chk("ovf_we", 32'(we), 32'd0);
    tick();
    chk("ovf_err", 32'(wr_err), 32'd1);
    chk("ovf_state", 32'(state), 32'd3);
    chk("ovf_count", 32'(data_count), 32'd8);

    // Drain.
    for (int i = 0; i < 8; i++) begin
      v = 32'h11111111 * (i + 1);
      op(0, 1, 0);
      chk("drain_sel", 32'(rd_sel), i);
      tick();
      chk("drain_ack", 32'(rd_ack), 32'd1);
      chk("drain_data", rdreg, v);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    op(0, 1, 0);
    tick();
    chk("udf_err", 32'(rd_err), 32'd1);
    chk("udf_state", 32'(state), 32'd5);
    op(0, 0, 0);
    tick();
    chk("idle_state", 32'(state), 32'd1);
    chk("idle_flags", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);

    // Wrap: write 6, read 6, write 5 crossing tail 7 -> 0.
    for (int i = 0; i < 6; i++) begin op(1, 0, 32'hA0 + i); tick(); end
    for (int i = 0; i < 6; i++) begin op(0, 1, 0); tick(); end
    wrap_we[0] = 8'h40; wrap_we[1] = 8'h80; wrap_we[2] = 8'h01;
    wrap_we[3] = 8'h02; wrap_we[4] = 8'h04;
    for (int i = 0; i < 5; i++) begin
      wrap_val[i] = 32'hC0DE0000 + i;
      op(1, 0, wrap_val[i]);
      chk("wrap_we", 32'(we), 32'(wrap_we[i]));
      tick();
    end
    chk("wrap_count", 32'(data_count), 32'd5);
    for (int i = 0; i < 5; i++) begin
      op(0, 1, 0);
      tick();
      chk("wrap_data", rdreg, wrap_val[i]);
    end

    // Simultaneous request with count 4.
    for (int i = 0; i < 4; i++) begin op(1, 0, 32'h5000 + i); tick(); end
    op(1, 1, 32'hFFFF);
    chk("sim_we", 32'(we), 32'd0);
    tick();
    chk("sim_state", 32'(state), 32'd1);
    chk("sim_count", 32'(data_count), 32'd4);
    chk("sim_flags", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);

    // Asynchronous reset mid-cycle with count 3.
    op(0, 1, 0);
    tick();
    op(0, 0, 0);
    #2;
    reset_n = 0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_count", 32'(data_count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_we", 32'(we), 32'd0);
    chk("arst_flags", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);
    @(posedge clk);
    #3;
    reset_n = 1;

    // Random traffic with fill/drain bias phases and occasional resets.
    phase_wr = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) phase_wr = $urandom_range(15, 85);
      if ($urandom_range(0, 99) < 8) op(1, 1, $urandom);
      else if ($urandom_range(0, 99) < phase_wr) op(1, 0, $urandom);
      else if ($urandom_range(0, 99) < 85) op(0, 1, 0);
      else op(0, 0, 0);
      tick();
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset_n = 0;
        @(posedge clk);
        #3;
        reset_n = 1;
      end
    end
    op(0, 0, 0);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
